// File: rtl/operand_fetch.sv
// Decode/operand-fetch stage: decodes ARM data-processing instructions, forms
// operands, tracks pending destination registers and feeds the ID/EX register.
module operand_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [3:0]  rf_read_addr1,
  output logic [3:0]  rf_read_addr2,
  input  logic [31:0] rf_read_data1,
  input  logic [31:0] rf_read_data2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_cond,
  output logic [3:0]  out_opcode,
  output logic        out_set_flags,
  output logic [3:0]  out_rd,
  output logic        out_writes_rd,
  output logic        out_illegal,
  output logic [31:0] out_op_a,
  output logic [31:0] out_op_b,
  input  logic        wb_valid,
  input  logic [3:0]  wb_addr,
  input  logic        flush
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 16;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_next;
  logic            is_dp;
  logic            uses_rn;
  logic            uses_rm;
  logic            writes_rd;
  logic            hazard;
  logic            accept;
  logic [3:0]      opcode;
  logic [3:0]      rd;
  logic [4:0]      imm_rot;
  logic [4:0]      shamt;
  logic [XLEN-1:0] imm_c;
  logic [XLEN-1:0] shift_c;
  logic [XLEN-1:0] op_a_c;
  logic [XLEN-1:0] op_b_c;

  assign rf_read_addr1 = in_instr[19:16];
  assign rf_read_addr2 = in_instr[3:0];
  assign opcode        = in_instr[24:21];
  assign rd            = in_instr[15:12];

  // Instruction class decode; non-DP instructions touch no registers
  always_comb begin
    is_dp     = (in_instr[27:26] == 2'b00);
    uses_rn   = is_dp && (opcode != 4'b1101) && (opcode != 4'b1111);
    writes_rd = is_dp && (opcode[3:2] != 2'b10);
    uses_rm   = is_dp && !in_instr[25];
  end

  // Operand 2: rotated immediate or immediate-shifted register
  always_comb begin
    imm_rot = {in_instr[11:8], 1'b0};
    shamt   = in_instr[11:7];
    imm_c   = XLEN'({2{24'd0, in_instr[7:0]}} >> imm_rot);
    case (in_instr[6:5])
      2'b00:   shift_c = rf_read_data2 << shamt;
      2'b01:   shift_c = rf_read_data2 >> shamt;
      2'b10:   shift_c = XLEN'($signed(rf_read_data2) >>> shamt);
      default: shift_c = XLEN'({rf_read_data2, rf_read_data2} >> shamt);
    endcase
    op_a_c = uses_rn ? rf_read_data1 : '0;
    op_b_c = '0;
    if (is_dp) op_b_c = in_instr[25] ? imm_c : shift_c;
  end

  always_comb begin
    hazard   = (uses_rn && busy[rf_read_addr1]) ||
               (uses_rm && busy[rf_read_addr2]) ||
               (writes_rd && busy[rd]);
    in_ready = !flush && !hazard && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
  end

  // Scoreboard update: squash and retire clear, a new accept sets last
  always_comb begin
    busy_next = busy;
    if (flush && out_valid && out_writes_rd) busy_next[out_rd] = 1'b0;
    if (wb_valid) busy_next[wb_addr] = 1'b0;
    if (accept && writes_rd) busy_next[rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy          <= '0;
      out_valid     <= 1'b0;
      out_cond      <= '0;
      out_opcode    <= '0;
      out_set_flags <= 1'b0;
      out_rd        <= '0;
      out_writes_rd <= 1'b0;
      out_illegal   <= 1'b0;
      out_op_a      <= '0;
      out_op_b      <= '0;
    end else begin
      busy <= busy_next;
      if (flush)          out_valid <= 1'b0;
      else if (accept)    out_valid <= 1'b1;
      else if (out_ready) out_valid <= 1'b0;
      if (accept) begin
        out_cond      <= in_instr[31:28];
        out_opcode    <= opcode;
        out_set_flags <= in_instr[20];
        out_rd        <= rd;
        out_writes_rd <= writes_rd;
        out_illegal   <= !is_dp;
        out_op_a      <= op_a_c;
        out_op_b      <= op_b_c;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Randomized self-checking bench for operand_fetch against a behavioural
// model of the decode rules, scoreboard and ID/EX register.
module tb_operand_fetch;

  typedef struct packed {
    logic [3:0]  cond;
    logic [3:0]  opcode;
    logic        set_flags;
    logic [3:0]  rd;
    logic        writes_rd;
    logic        illegal;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, rf_read_data1, rf_read_data2, out_op_a, out_op_b;
  logic [3:0]  rf_read_addr1, rf_read_addr2, out_cond, out_opcode, out_rd, wb_addr;
  logic        out_set_flags, out_writes_rd, out_illegal, wb_valid, flush;

  logic [31:0] regs [16];
  bit   [15:0] m_busy;
  bit          m_valid;
  ent_t        m_ent;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        last_ready;

  always #5 clk = ~clk;

  assign rf_read_data1 = regs[rf_read_addr1];
  assign rf_read_data2 = regs[rf_read_addr2];

  operand_fetch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .rf_read_addr1(rf_read_addr1), .rf_read_addr2(rf_read_addr2),
    .rf_read_data1(rf_read_data1), .rf_read_data2(rf_read_data2),
    .out_valid(out_valid), .out_ready(out_ready), .out_cond(out_cond),
    .out_opcode(out_opcode), .out_set_flags(out_set_flags), .out_rd(out_rd),
    .out_writes_rd(out_writes_rd), .out_illegal(out_illegal),
    .out_op_a(out_op_a), .out_op_b(out_op_b), .wb_valid(wb_valid),
    .wb_addr(wb_addr), .flush(flush)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    if (n == 0) return x;
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic bit is_cmp(input logic [3:0] op);
    return op inside {4'd8, 4'd9, 4'd10, 4'd11};
  endfunction

  function automatic bit no_rn(input logic [3:0] op);
    return op == 4'd13 || op == 4'd15;
  endfunction

  function automatic ent_t model_decode(input logic [31:0] ins);
    ent_t        e;
    int          amt;
    logic [31:0] rm;
    e           = '0;
    e.cond      = ins[31:28];
    e.opcode    = ins[24:21];
    e.set_flags = ins[20];
    e.rd        = ins[15:12];
    if (ins[27:26] != 2'b00) begin
      e.illegal = 1'b1;
      return e;
    end
    e.writes_rd = !is_cmp(ins[24:21]);
    e.op_a      = no_rn(ins[24:21]) ? 32'd0 : regs[ins[19:16]];
    if (ins[25]) begin
      e.op_b = ror32({24'd0, ins[7:0]}, 2 * int'(ins[11:8]));
    end else begin
      amt = int'(ins[11:7]);
      rm  = regs[ins[3:0]];
      case (ins[6:5])
        2'b00:   e.op_b = rm << amt;
        2'b01:   e.op_b = rm >> amt;
        2'b10:   e.op_b = (amt == 0) ? rm : (rm[31] ? ~((~rm) >> amt) : rm >> amt);
        default: e.op_b = ror32(rm, amt);
      endcase
    end
    return e;
  endfunction

  function automatic bit model_hazard(input logic [31:0] ins);
    bit h;
    if (ins[27:26] != 2'b00) return 1'b0;
    h = 1'b0;
    if (!no_rn(ins[24:21]) && m_busy[ins[19:16]]) h = 1'b1;
    if (!ins[25] && m_busy[ins[3:0]]) h = 1'b1;
    if (!is_cmp(ins[24:21]) && m_busy[ins[15:12]]) h = 1'b1;
    return h;
  endfunction

  // One clock: drive at negedge, check in_ready, advance model, check outputs
  task automatic step(input bit r, input bit iv, input logic [31:0] ins, input bit ordy,
                      input bit wv, input logic [3:0] wa, input bit fl);
    bit          exp_ready;
    bit          acc;
    ent_t        e;
    bit   [15:0] nb;
    @(negedge clk);
    rst = r; in_valid = iv; in_instr = ins; out_ready = ordy;
    wb_valid = wv; wb_addr = wa; flush = fl;
    #1;
    e         = model_decode(ins);
    exp_ready = !fl && !model_hazard(ins) && (!m_valid || ordy);
    check("in_ready", 32'(in_ready), 32'(exp_ready));
    check("rf_addrs", {24'd0, rf_read_addr1, rf_read_addr2}, {24'd0, ins[19:16], ins[3:0]});
    last_ready = in_ready;
    acc = iv && exp_ready;
    if (!r) begin
      m_valid = 1'b0;
      m_busy  = '0;
      m_ent   = '0;
    end else begin
      nb = m_busy;
      if (fl && m_valid && m_ent.writes_rd) nb[m_ent.rd] = 1'b0;
      if (wv) nb[wa] = 1'b0;
      if (acc && e.writes_rd) nb[e.rd] = 1'b1;
      m_busy = nb;
      if (fl) m_valid = 1'b0;
      else if (acc) m_valid = 1'b1;
      else if (ordy) m_valid = 1'b0;
      if (acc) m_ent = e;
    end
    @(posedge clk);
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("busy", 32'(dut.busy), 32'(m_busy));
    if (m_valid || !r) begin
      check("fields", {17'd0, out_cond, out_opcode, out_set_flags, out_rd, out_writes_rd, out_illegal},
            {17'd0, m_ent.cond, m_ent.opcode, m_ent.set_flags, m_ent.rd, m_ent.writes_rd, m_ent.illegal});
      check("op_a", out_op_a, m_ent.op_a);
      check("op_b", out_op_b, m_ent.op_b);
    end
  endtask

  task automatic issue(input logic [31:0] ins);
    step(1'b1, 1'b1, ins, 1'b1, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic retire(input logic [3:0] a);
    step(1'b1, 1'b0, 32'd0, 1'b1, 1'b1, a, 1'b0);
  endtask

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_addr = '0; flush = 1'b0; last_ready = 1'b0;
    m_busy = '0; m_valid = 1'b0; m_ent = '0;
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    regs[2] = 32'h10;
    regs[5] = 32'hF;

    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 1'b0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_opb", out_op_b, 32'd0);

    issue(32'hE2821005);
    check("add_opcode", 32'(out_opcode), 32'd4);
    check("add_rd", 32'(out_rd), 32'd1);
    check("add_opa", out_op_a, 32'h10);
    check("add_opb", out_op_b, 32'd5);
    check("add_busy1", 32'(dut.busy[1]), 32'd1);

    issue(32'hE3A004FF);
    check("mov_imm_opb", out_op_b, 32'hFF000000);
    check("mov_imm_opa", out_op_a, 32'd0);
    check("mov_imm_wr", 32'(out_writes_rd), 32'd1);
    retire(4'd1);
    retire(4'd0);

    issue(32'hE1A04205);
    check("lsl4", out_op_b, 32'hF0);
    regs[5] = 32'h80000001;
    retire(4'd4);
    issue(32'hE1A04225);
    check("lsr4", out_op_b, 32'h08000000);
    retire(4'd4);
    issue(32'hE1A04245);
    check("asr4", out_op_b, 32'hF8000000);
    retire(4'd4);
    issue(32'hE1A04265);
    check("ror4", out_op_b, 32'h18000000);
    retire(4'd4);

    issue(32'hE2821005);
    step(1'b1, 1'b1, 32'hE0413002, 1'b1, 1'b0, 4'd0, 1'b0);
    check("raw_stall0", 32'(last_ready), 32'd0);
    step(1'b1, 1'b1, 32'hE0413002, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b1, 1'b1, 32'hE0413002, 1'b1, 1'b1, 4'd1, 1'b0);
    check("raw_wb_edge", 32'(last_ready), 32'd0);
    issue(32'hE0413002);
    check("raw_issue", 32'(last_ready), 32'd1);
    check("sub_rd", 32'(out_rd), 32'd3);

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 32'hE2876001, 1'b0, 1'b0, 4'd0, 1'b0);
      check("bp_ready", 32'(last_ready), 32'd0);
      check("bp_opb", out_op_b, 32'h10);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    step(1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 4'd0, 1'b1);
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_busy3", 32'(dut.busy[3]), 32'd0);

    issue(32'hE2821005);
    step(1'b1, 1'b1, 32'hE0413002, 1'b1, 1'b0, 4'd0, 1'b0);
    step(1'b0, 1'b1, 32'hE0413002, 1'b1, 1'b0, 4'd0, 1'b0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_busy", 32'(dut.busy), 32'd0);
    issue(32'hE7900001);
    check("ldr_illegal", 32'(out_illegal), 32'd1);
    check("ldr_wr", 32'(out_writes_rd), 32'd0);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] ins;
      logic [3:0]  wa;
      bit          wv;
      int          start;
      regs[$urandom_range(0, 15)] = $urandom;
      ins = $urandom;
      if ($urandom_range(0, 7) != 0) ins[27:26] = 2'b00;
      wv = 1'b0;
      wa = 4'($urandom_range(0, 15));
      if (m_busy != 0 && $urandom_range(0, 1) == 1) begin
        start = $urandom_range(0, 15);
        for (int k = 0; k < 16; k++) begin
          if (!wv && m_busy[(start + k) % 16]) begin
            wv = 1'b1;
            wa = 4'((start + k) % 16);
          end
        end
      end
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 3) != 0), ins,
           ($urandom_range(0, 3) != 0), wv, wa, ($urandom_range(0, 15) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
# operand_fetch

- Decode/operand-fetch stage of the CPU pipeline.
- Sits directly upstream of the 16×32 register file: takes one ARM data-processing instruction per cycle over a valid/ready handshake, drives the register file read addresses, forms operand B, and registers everything into the ID/EX pipeline register.
- Holds a 16-entry busy scoreboard and stalls instructions with RAW/WAW hazards until the writeback stage retires the pending register.

## Interface
Parameters: none.
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  in_instr valid
- in_ready  out  1  stage accepts in_instr this cycle
- in_instr  in  32  ARM instruction word
- rf_read_addr1  out  4  Rn, combinational from in_instr[19:16]
- rf_read_addr2  out  4  Rm, combinational from in_instr[3:0]
- rf_read_data1  in  32  register file data for rf_read_addr1
- rf_read_data2  in  32  register file data for rf_read_addr2
- out_valid  out  1  ID/EX register holds an instruction
- out_ready  in  1  execute stage consumes it
- out_cond  out  4  instr[31:28]
- out_opcode  out  4  instr[24:21]
- out_set_flags  out  1  instr[20]
- out_rd  out  4  instr[15:12]
- out_writes_rd  out  1  instruction writes Rd
- out_illegal  out  1  not a data-processing instruction
- out_op_a  out  32  Rn value (0 when Rn unused)
- out_op_b  out  32  formed operand 2
- wb_valid  in  1  writeback retiring a register this cycle
- wb_addr  in  4  register being retired
- flush  in  1  squash the ID/EX register

## Operation
- Data-processing only: instr[27:26]==00. Otherwise out_illegal=1, out_writes_rd=0, no scoreboard use, operands 0.
- uses_rn = 0 for MOV (1101) and MVN (1111); otherwise 1.
- writes_rd = 0 for TST/TEQ/CMP/CMN (1000–1011); otherwise 1.
- uses_rm = !instr[25].
- Immediate (I=1): op_b = {24'b0, instr[7:0]} rotated right by 2*instr[11:8].
- Register (I=0): op_b = Rm shifted by instr[11:7], type instr[6:5]: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
  - Amount 0 means no shift for all types; no RRX, no register-specified shifts.
- R15 reads return the register file contents; the PC is not modeled here.
- Scoreboard: busy[15:0].
  - hazard = (uses_rn && busy[Rn]) || (uses_rm && busy[Rm]) || (writes_rd && busy[Rd]).
- in_ready = !flush && !hazard && (!out_valid || out_ready).
- Accept (in_valid && in_ready): load the ID/EX register, set out_valid, set busy[Rd] if writes_rd.
- out_valid clears when out_ready is high and no new accept occurs.
- wb_valid clears busy[wb_addr].
  - If the same edge sets the same bit on accept, set wins.
- flush: clears out_valid and clears busy[out_rd] if the squashed entry had out_writes_rd; no accept that cycle. Bits of older in-flight instructions stay set.

## Timing
- Reset values: out_valid=0, busy=0, all out_* data=0. rst low mid-operation discards the held instruction and all busy bits on that edge.
- Latency: 1 cycle, accept edge to out_valid. Throughput: 1 instruction/cycle without hazards or backpressure.
- rf_read_addr* and rf_read_data* are combinational within the cycle and sampled on the accept edge.
- Hazard check uses registered busy.
  - A stalled instruction issues the cycle after the edge where wb_valid clears its bit.
  - No bypass from wb.
- Output data holds stable while out_valid && !out_ready.
- Simultaneous flush and wb_valid: both clears apply.

## Test plan
- Reset, then ADD R1,R2,#5 (0xE2821005) with R2=0x10.
  - Next cycle: out_valid=1, out_opcode=0100, out_rd=1, out_op_a=0x10, out_op_b=5, busy[1]=1.
- MOV R0,#0xFF000000 (0xE3A004FF).
  - out_op_b=0xFF000000, out_op_a=0, out_writes_rd=1.
- MOV R4,R5,LSL #4 (0xE1A04205) with R5=0xF.
  - out_op_b=0xF0.
  - Repeat with LSR/ASR/ROR against a reference model using R5=0x80000001.
- RAW stall: accept 0xE2821005, then present SUB R3,R1,R2 (0xE0413002).
  - in_ready=0 until wb_valid=1, wb_addr=1.
  - The SUB is accepted the following cycle.
- Backpressure and flush: hold out_ready=0 for 3 cycles.
  - Outputs stay stable and in_ready=0.
  - Assert flush: out_valid=0 next cycle and busy[out_rd] cleared.
- Assert rst low while an instruction is stalled and busy≠0.
  - Next cycle: out_valid=0, busy=0.
  - Presenting 0xE7900001 (LDR) yields out_illegal=1, out_writes_rd=0.
